phase_sequencer: RTL and testbench

//   Control sequencer for the 16-bit SIMPLE datapath: steps fetch/decode/execute through phases
//   P1 (fetch), P2 (register read), P3 (ALU/address), P4 (memory) and P5 (writeback/branch).

---
 rtl/phase_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_phase_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_sequencer.sv
// Control sequencer for the 16-bit SIMPLE datapath: walks fetch/decode/execute phases P1..P5,
// decodes per-phase datapath enables and owns the memory handshake, HALT and ack-timeout fault.
module phase_sequencer #(
  parameter int unsigned ACK_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [15:0]      ir,
  input  logic [3:0]       flags,
  input  logic             mem_ack,
  output logic [4:0]       phase,
  output logic             busy,
  output logic             halted,
  output logic             fault,
  output logic             mem_req,
  output logic             mem_we,
  output logic             ir_load,
  output logic             pc_inc,
  output logic             reg_read,
  output logic             alu_en,
  output logic             flag_we,
  output logic             dr_load,
  output logic             reg_we,
  output logic             pc_load,
  output logic             out_en,
  output logic             in_en,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    StIdle, StP1, StP2, StP3, StP4, StP5, StHalted, StFault
  } state_e;

  // Last wait count that may still see an ack; one more empty cycle means fault.
  localparam logic [15:0] WaitLast = 16'(ACK_TIMEOUT - 1);

  state_e           state_q;
  logic [15:0]      wait_q;
  logic [CNT_W-1:0] retired_q;

  logic [1:0] cls;
  logic [3:0] op;
  logic [2:0] sub;
  logic [2:0] cond;
  logic       flag_v, flag_z, flag_s;
  logic       is_alu_cls, is_halt, is_out, is_in, is_cmp;
  logic       is_load, is_store, is_mem;
  logic       cond_true, branch_taken, writes_flags, writes_reg;
  logic       unused;

  assign cls    = ir[15:14];
  assign op     = ir[7:4];
  assign sub    = ir[13:11];
  assign cond   = ir[10:8];
  assign flag_v = flags[3];
  assign flag_z = flags[1];
  assign flag_s = flags[0];
  assign unused = ^{ir[3:0], flags[2]};

  assign is_alu_cls = (cls == 2'b11);
  assign is_halt    = is_alu_cls && (op == 4'b1111);
  assign is_out     = is_alu_cls && (op == 4'b1101);
  assign is_in      = is_alu_cls && (op == 4'b1100);
  assign is_cmp     = is_alu_cls && (op == 4'b0101);
  assign is_load    = (cls == 2'b00);
  assign is_store   = (cls == 2'b01);
  assign is_mem     = is_load || is_store;

  always_comb begin
    cond_true = 1'b0;
    unique case (cond)
      3'b000:  cond_true = flag_z;
      3'b001:  cond_true = flag_s ^ flag_v;
      3'b010:  cond_true = flag_z | (flag_s ^ flag_v);
      3'b011:  cond_true = ~flag_z;
      default: cond_true = 1'b0;
    endcase
  end

  assign branch_taken = (cls == 2'b10) &&
                        ((sub == 3'b100) || ((sub == 3'b111) && cond_true));
  assign writes_flags = is_alu_cls && !is_out && !is_in && !is_halt;
  assign writes_reg   = is_load || ((cls == 2'b10) && (sub == 3'b000)) ||
                        (is_alu_cls && !is_cmp && !is_out && !is_halt);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      wait_q    <= '0;
      retired_q <= '0;
    end else begin
      unique case (state_q)
        StIdle, StHalted: begin
          if (start) begin
            state_q <= StP1;
            wait_q  <= '0;
          end
        end
        StP1: begin
          if (mem_ack)                state_q <= StP2;
          else if (wait_q == WaitLast) state_q <= StFault;
          else                        wait_q  <= wait_q + 16'd1;
        end
        StP2: state_q <= StP3;
        StP3: begin
          if (is_halt) begin
            state_q   <= StHalted;
            retired_q <= retired_q + CNT_W'(1);
          end else if (is_mem) begin
            state_q <= StP4;
            wait_q  <= '0;
          end else begin
            state_q <= StP5;
          end
        end
        StP4: begin
          if (mem_ack)                state_q <= StP5;
          else if (wait_q == WaitLast) state_q <= StFault;
          else                        wait_q  <= wait_q + 16'd1;
        end
        StP5: begin
          state_q   <= StP1;
          wait_q    <= '0;
          retired_q <= retired_q + CNT_W'(1);
        end
        StFault: state_q <= StFault;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Outputs decode straight from state and the live ir/flags/mem_ack inputs.
  always_comb begin
    phase    = 5'b00000;
    busy     = 1'b0;
    halted   = 1'b0;
    fault    = 1'b0;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    ir_load  = 1'b0;
    pc_inc   = 1'b0;
    reg_read = 1'b0;
    alu_en   = 1'b0;
    flag_we  = 1'b0;
    dr_load  = 1'b0;
    reg_we   = 1'b0;
    pc_load  = 1'b0;
    out_en   = 1'b0;
    in_en    = 1'b0;
    unique case (state_q)
      StP1: begin
        phase   = 5'b00001;
        busy    = 1'b1;
        mem_req = 1'b1;
        ir_load = mem_ack;
        pc_inc  = mem_ack;
      end
      StP2: begin
        phase    = 5'b00010;
        busy     = 1'b1;
        reg_read = 1'b1;
      end
      StP3: begin
        phase   = 5'b00100;
        busy    = 1'b1;
        alu_en  = 1'b1;
        flag_we = writes_flags;
        in_en   = is_in;
      end
      StP4: begin
        phase   = 5'b01000;
        busy    = 1'b1;
        mem_req = 1'b1;
        mem_we  = is_store;
        dr_load = is_load && mem_ack;
      end
      StP5: begin
        phase   = 5'b10000;
        busy    = 1'b1;
        reg_we  = writes_reg;
        pc_load = branch_taken;
        out_en  = is_out;
      end
      StHalted: halted = 1'b1;
      StFault:  fault  = 1'b1;
      default: ;
    endcase
  end

  assign retired = retired_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Randomised bench for phase_sequencer: an instruction-level model plans the expected per-cycle
// outputs from each instruction's decode and the chosen ack delays, then checks every cycle.
module tb_phase_sequencer;

  localparam int unsigned Timeout = 8;
  localparam int unsigned CntW    = 4;

  typedef struct packed {
    logic [4:0] phase;
    logic busy, halted, fault, mem_req, mem_we, ir_load, pc_inc, reg_read;
    logic alu_en, flag_we, dr_load, reg_we, pc_load, out_en, in_en;
  } outs_t;

  logic clock = 1'b0;
  logic reset, start, mem_ack;
  logic [15:0] ir;
  logic [3:0]  flags;
  logic [4:0]  phase;
  logic busy, halted, fault, mem_req, mem_we, ir_load, pc_inc, reg_read;
  logic alu_en, flag_we, dr_load, reg_we, pc_load, out_en, in_en;
  logic [CntW-1:0] retired;
  outs_t act;

  int          n_vec;
  int          n_bad;
  int unsigned n_ret;

  always #5 clock = ~clock;

  phase_sequencer #(
    .ACK_TIMEOUT(Timeout),
    .CNT_W      (CntW)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .ir      (ir),
    .flags   (flags),
    .mem_ack (mem_ack),
    .phase   (phase),
    .busy    (busy),
    .halted  (halted),
    .fault   (fault),
    .mem_req (mem_req),
    .mem_we  (mem_we),
    .ir_load (ir_load),
    .pc_inc  (pc_inc),
    .reg_read(reg_read),
    .alu_en  (alu_en),
    .flag_we (flag_we),
    .dr_load (dr_load),
    .reg_we  (reg_we),
    .pc_load (pc_load),
    .out_en  (out_en),
    .in_en   (in_en),
    .retired (retired)
  );

  assign act = {phase, busy, halted, fault, mem_req, mem_we, ir_load, pc_inc, reg_read,
                alu_en, flag_we, dr_load, reg_we, pc_load, out_en, in_en};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic noise();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic outs_t in_phase(input int p);
    outs_t e;
    e       = '0;
    e.phase = 5'(1 << p);
    e.busy  = 1'b1;
    return e;
  endfunction

  // One clock: drive inputs on the falling edge, check settled outputs 1ns later.
  task automatic step(input outs_t exp, input logic ack, input logic st, input logic rst,
                      input bit chk, input string tag);
    @(negedge clock);
    mem_ack = ack;
    start   = st;
    reset   = rst;
    #1;
    if (chk) begin
      check_eq({tag, " outs"}, 32'(act), 32'(exp));
      check_eq({tag, " retired"}, 32'(retired), 32'(n_ret % (1 << CntW)));
    end
  endtask

  // Entered with the DUT in P1; leaves it entering P1 again (restarting after HALT if needed).
  task automatic run_instr(input logic [15:0] iv, input logic [3:0] fv, input int d1,
                           input int d4);
    logic [1:0] cls;
    logic [3:0] op;
    logic [2:0] sub, cond;
    logic       v, z, s, taken;
    outs_t      e;
    ir    = iv;
    flags = fv;
    cls   = iv[15:14];
    op    = iv[7:4];
    sub   = iv[13:11];
    cond  = iv[10:8];
    v     = fv[3];
    z     = fv[1];
    s     = fv[0];
    taken = 1'b0;
    if (cls == 2'd2) begin
      if (sub == 3'd4) taken = 1'b1;
      else if (sub == 3'd7) begin
        case (cond)
          3'd0:    taken = z;
          3'd1:    taken = s ^ v;
          3'd2:    taken = z | (s ^ v);
          3'd3:    taken = !z;
          default: taken = 1'b0;
        endcase
      end
    end
    for (int i = 0; i < d1; i++) begin
      e = in_phase(0);
      e.mem_req = 1'b1;
      step(e, 1'b0, noise(), 1'b0, 1'b1, "p1 wait");
    end
    e = in_phase(0);
    e.mem_req = 1'b1;
    e.ir_load = 1'b1;
    e.pc_inc  = 1'b1;
    step(e, 1'b1, noise(), 1'b0, 1'b1, "p1 ack");
    e = in_phase(1);
    e.reg_read = 1'b1;
    step(e, noise(), noise(), 1'b0, 1'b1, "p2");
    e = in_phase(2);
    e.alu_en  = 1'b1;
    e.flag_we = (cls == 2'd3) && !(op inside {4'd12, 4'd13, 4'd15});
    e.in_en   = (cls == 2'd3) && (op == 4'd12);
    step(e, noise(), noise(), 1'b0, 1'b1, "p3");
    if (cls == 2'd3 && op == 4'd15) begin
      n_ret++;
      e = '0;
      e.halted = 1'b1;
      repeat ($urandom_range(0, 2)) step(e, noise(), 1'b0, 1'b0, 1'b1, "halted");
      step(e, noise(), 1'b1, 1'b0, 1'b1, "halted start");
      return;
    end
    if (cls < 2'd2) begin
      for (int i = 0; i < d4; i++) begin
        e = in_phase(3);
        e.mem_req = 1'b1;
        e.mem_we  = (cls == 2'd1);
        step(e, 1'b0, noise(), 1'b0, 1'b1, "p4 wait");
      end
      e = in_phase(3);
      e.mem_req = 1'b1;
      e.mem_we  = (cls == 2'd1);
      e.dr_load = (cls == 2'd0);
      step(e, 1'b1, noise(), 1'b0, 1'b1, "p4 ack");
    end
    e = in_phase(4);
    e.reg_we  = (cls == 2'd0) || (cls == 2'd2 && sub == 3'd0) ||
                (cls == 2'd3 && !(op inside {4'd5, 4'd13, 4'd15}));
    e.pc_load = taken;
    e.out_en  = (cls == 2'd3) && (op == 4'd13);
    step(e, noise(), noise(), 1'b0, 1'b1, "p5");
    n_ret++;
  endtask

  localparam int NDir = 16;
  logic [15:0] dir_ir [NDir] = '{16'hC000, 16'h0000, 16'h4000, 16'hB800, 16'hB800, 16'hC050,
                                 16'hC0D0, 16'hC0C0, 16'hA000, 16'h8000, 16'h8800, 16'hC0F0,
                                 16'hB900, 16'hBA00, 16'hBB00, 16'hBC00};
  logic [3:0]  dir_fl [NDir] = '{4'h0, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0,
                                 4'h0, 4'h0, 4'h0, 4'h0, 4'h8, 4'h0, 4'h0, 4'hF};
  int          dir_d1 [NDir] = '{0, 0, 2, 0, 1, 0, 0, 0, 0, 7, 0, 0, 0, 3, 0, 0};
  int          dir_d4 [NDir] = '{0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

  initial begin
    outs_t e;
    n_vec   = 0;
    n_bad   = 0;
    n_ret   = 0;
    reset   = 1'b1;
    start   = 1'b0;
    mem_ack = 1'b0;
    ir      = '0;
    flags   = '0;

    step('0, 1'b0, 1'b0, 1'b1, 1'b0, "reset");
    step('0, 1'b1, 1'b1, 1'b1, 1'b1, "reset wins");
    step('0, 1'b0, 1'b0, 1'b0, 1'b1, "idle");
    step('0, 1'b1, 1'b1, 1'b0, 1'b1, "idle start");

    for (int i = 0; i < NDir; i++) run_instr(dir_ir[i], dir_fl[i], dir_d1[i], dir_d4[i]);
    for (int i = 0; i < 60; i++) begin
      run_instr(16'($urandom), 4'($urandom), int'($urandom_range(0, Timeout - 1)),
                int'($urandom_range(0, Timeout - 1)));
    end

    // Ack never arrives in P1: Timeout empty cycles then a sticky fault.
    ir = 16'h0000;
    for (int i = 0; i < int'(Timeout); i++) begin
      e = in_phase(0);
      e.mem_req = 1'b1;
      step(e, 1'b0, noise(), 1'b0, 1'b1, "timeout wait");
    end
    e = '0;
    e.fault = 1'b1;
    step(e, 1'b1, 1'b1, 1'b0, 1'b1, "fault");
    step(e, 1'b1, 1'b1, 1'b0, 1'b1, "fault sticky");
    step(e, 1'b0, 1'b0, 1'b1, 1'b1, "fault reset");
    n_ret = 0;
    step('0, 1'b0, 1'b0, 1'b0, 1'b1, "idle after fault");

    // Reset while waiting in P4, then a late ack must be ignored in IDLE.
    step('0, 1'b0, 1'b1, 1'b0, 1'b1, "idle start 2");
    e = in_phase(0);
    e.mem_req = 1'b1;
    e.ir_load = 1'b1;
    e.pc_inc  = 1'b1;
    step(e, 1'b1, 1'b0, 1'b0, 1'b1, "mid p1");
    e = in_phase(1);
    e.reg_read = 1'b1;
    step(e, 1'b0, 1'b0, 1'b0, 1'b1, "mid p2");
    e = in_phase(2);
    e.alu_en = 1'b1;
    step(e, 1'b0, 1'b0, 1'b0, 1'b1, "mid p3");
    e = in_phase(3);
    e.mem_req = 1'b1;
    step(e, 1'b0, 1'b0, 1'b0, 1'b1, "mid p4");
    step(e, 1'b0, 1'b0, 1'b1, 1'b1, "mid p4 reset");
    step('0, 1'b1, 1'b0, 1'b0, 1'b1, "idle late ack");
    step('0, 1'b1, 1'b0, 1'b0, 1'b1, "idle stays");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
